muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the EX stage. It takes the same forwarded operands that the rs1/rs2 operand muxes present to the ALU (ALUINA/ALUINB) and computes all eight M-extension ops over a fixed 33-cycle latency. The result goes to the EX/MEM register, and the hazard unit uses `busy` to stall the front of the pipe while an operation is running.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Operand/result bundle between the EX-stage operand muxes and the iterative
// RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ALUINA;
    logic [XLEN-1:0] ALUINB;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] MDOUT;

    modport master (
        output start, funct3, ALUINA, ALUINB, flush,
        input  busy, done, MDOUT
    );

    modport slave (
        input  start, funct3, ALUINA, ALUINB, flush,
        output busy, done, MDOUT
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add multiply and
// restoring divide, fixed 33-cycle latency, sign/special-case fixup at the end.
module muldiv_unit #(
    parameter int XLEN = 32  // only 32 is supported
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t            state;
    state_t            state_next;
    logic              accept;

    op_t               op;
    logic              neg_a;
    logic              neg_b;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;
    logic [5:0]        count;

    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   mdout_q;

    // Launch-time operand decode
    logic              is_div_in;
    logic              signed_a_in;
    logic              signed_b_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;

    // Per-iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_take;
    logic [2*XLEN-1:0] div_next;

    // Fixup datapath
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.MDOUT = mdout_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (count == 6'(XLEN - 1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_div_in   = bus.funct3[2];
        signed_a_in = is_div_in ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        signed_b_in = is_div_in ? !bus.funct3[0] : !bus.funct3[1];
        neg_a_in    = signed_a_in && bus.ALUINA[XLEN-1];
        neg_b_in    = signed_b_in && bus.ALUINB[XLEN-1];
        mag_a_in    = neg_a_in ? -bus.ALUINA : bus.ALUINA;
        mag_b_in    = neg_b_in ? -bus.ALUINB : bus.ALUINB;
    end

    // Multiply: multiplier sits in acc low half and is consumed LSB first.
    // Divide: dividend sits in acc low half, quotient bits shift in behind it,
    // partial remainder lives in the high half.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        mul_next  = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                           : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_take  = (div_shift >= {1'b0, operand});
        div_next  = div_take
                  ? {div_shift[XLEN-1:0] - operand, acc[XLEN-2:0], 1'b1}
                  : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Divide-by-zero leaves the full dividend magnitude in the remainder, so
    // restoring the dividend sign reproduces the original ALUINA.
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        result   = '0;
        unique case (op)
            OP_MUL:                        result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div_zero)      result = '1;
                else if (overflow) result = {1'b1, {(XLEN-1){1'b0}}};
                else               result = quo_fix;
            end
            OP_REM, OP_REMU: begin
                if (div_zero)      result = rem_fix;
                else if (overflow) result = '0;
                else               result = rem_fix;
            end
            default:                       result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= OP_MUL;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mdout_q  <= '0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= 1'b0;
            if (accept) begin
                op       <= op_t'(bus.funct3);
                neg_a    <= neg_a_in;
                neg_b    <= neg_b_in;
                div_zero <= is_div_in && (bus.ALUINB == '0);
                overflow <= is_div_in && !bus.funct3[0]
                         && (bus.ALUINA == {1'b1, {(XLEN-1){1'b0}}})
                         && (bus.ALUINB == '1);
                operand  <= is_div_in ? mag_b_in : mag_a_in;
                acc      <= {{XLEN{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
                count    <= '0;
            end else if (state == CALC) begin
                acc   <= op[2] ? div_next : mul_next;
                count <= count + 6'd1;
            end
            if (state == FIXUP && !bus.flush) begin
                mdout_q <= result;
                done_q  <= 1'b1;
            end
        end
    end

endmodule
